// File: rtl/wreg_bank_if.sv
// Weight-register-bank bus: controller/PE-array side (master) to the bank (slave).
// Clock and reset are plain ports on the bank, not part of this bundle.
interface wreg_bank_if #(
    parameter int W_DATA_WIDTH = 8,
    parameter int W_ADDR_WIDTH = 9,
    parameter int W_NUM_REGS   = 9
);
    logic [W_DATA_WIDTH-1:0]            WRB_Data_In;
    logic                               WRB_Muxes_En;
    logic [W_ADDR_WIDTH-1:0]            WRB_Muxes_Sel;
    logic                               WRB_Loading_Regs_Already;
    logic                               WRB_Consume;
    logic                               WRB_Loading_Regs_Already_Ok;
    logic [W_NUM_REGS*W_DATA_WIDTH-1:0] WRB_Weights_Flat;
    logic                               WRB_Weights_Valid;
    logic                               WRB_Write_Error;

    modport master (
        output WRB_Data_In,
        output WRB_Muxes_En,
        output WRB_Muxes_Sel,
        output WRB_Loading_Regs_Already,
        output WRB_Consume,
        input  WRB_Loading_Regs_Already_Ok,
        input  WRB_Weights_Flat,
        input  WRB_Weights_Valid,
        input  WRB_Write_Error
    );

    modport slave (
        input  WRB_Data_In,
        input  WRB_Muxes_En,
        input  WRB_Muxes_Sel,
        input  WRB_Loading_Regs_Already,
        input  WRB_Consume,
        output WRB_Loading_Regs_Already_Ok,
        output WRB_Weights_Flat,
        output WRB_Weights_Valid,
        output WRB_Write_Error
    );
endinterface

// File: rtl/wreg_bank.sv
// Double-buffered kernel weight bank: the controller fills a load bank, which is swapped into
// the active bank once the PE array is done. Optional protocol checking: WREG_BANK_ERROR_CHECK_EN.
module wreg_bank #(
    parameter int W_DATA_WIDTH = 8,
    parameter int W_ADDR_WIDTH = 9,
    parameter int W_NUM_REGS   = 9
) (
    input  logic       WRB_Clk,
    input  logic       WRB_Reset,
    wreg_bank_if.slave bus
);
    localparam int FLAT_WIDTH = W_NUM_REGS * W_DATA_WIDTH;

    typedef enum logic [1:0] {
        FILL,
        SWAP_WAIT,
        ACK
    } state_t;

    state_t                state;
    logic [FLAT_WIDTH-1:0] load_flat;
    logic [FLAT_WIDTH-1:0] active_flat;
    logic                  weights_valid;
    logic                  already_ok;

    logic                  sel_in_range;
    logic                  write_fill;
    logic                  swap;

    assign sel_in_range = bus.WRB_Muxes_Sel < W_ADDR_WIDTH'(W_NUM_REGS);
    assign write_fill   = (state == FILL) && bus.WRB_Muxes_En && sel_in_range;
    // The swap may only overwrite the active bank once its kernel has been consumed.
    assign swap         = (state == SWAP_WAIT) && (!weights_valid || bus.WRB_Consume);

    always_ff @(posedge WRB_Clk) begin
        if (WRB_Reset) begin
            state         <= FILL;
            load_flat     <= '0;
            active_flat   <= '0;
            weights_valid <= 1'b0;
            already_ok    <= 1'b0;
        end else begin
            for (int i = 0; i < W_NUM_REGS; i++) begin
                if (write_fill && (bus.WRB_Muxes_Sel == W_ADDR_WIDTH'(i))) begin
                    load_flat[i*W_DATA_WIDTH +: W_DATA_WIDTH] <= bus.WRB_Data_In;
                end
            end

            if (swap) begin
                active_flat   <= load_flat;
                weights_valid <= 1'b1;
            end else if (bus.WRB_Consume) begin
                weights_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (bus.WRB_Loading_Regs_Already) begin
                        state <= SWAP_WAIT;
                    end
                end
                SWAP_WAIT: begin
                    if (swap) begin
                        state      <= ACK;
                        already_ok <= 1'b1;
                    end
                end
                ACK: begin
                    if (!bus.WRB_Loading_Regs_Already) begin
                        state      <= FILL;
                        already_ok <= 1'b0;
                    end
                end
                default: begin
                    state      <= FILL;
                    already_ok <= 1'b0;
                end
            endcase
        end
    end

    assign bus.WRB_Weights_Flat            = active_flat;
    assign bus.WRB_Weights_Valid           = weights_valid;
    assign bus.WRB_Loading_Regs_Already_Ok = already_ok;

`ifdef WREG_BANK_ERROR_CHECK_EN
    logic [W_NUM_REGS-1:0] written_mask;
    logic [W_NUM_REGS-1:0] write_onehot;
    logic [W_NUM_REGS-1:0] mask_next;
    logic                  error_hit;
    logic                  write_error;

    // A write in the same cycle as the pass-complete signal counts towards a complete mask.
    always_comb begin
        write_onehot = '0;
        for (int i = 0; i < W_NUM_REGS; i++) begin
            if (write_fill && (bus.WRB_Muxes_Sel == W_ADDR_WIDTH'(i))) begin
                write_onehot[i] = 1'b1;
            end
        end
        mask_next = written_mask | write_onehot;
        error_hit = (bus.WRB_Muxes_En && !sel_in_range)
                 || (bus.WRB_Muxes_En && (state != FILL))
                 || ((state == FILL) && bus.WRB_Loading_Regs_Already && !(&mask_next));
    end

    always_ff @(posedge WRB_Clk) begin
        if (WRB_Reset) begin
            written_mask <= '0;
            write_error  <= 1'b0;
        end else begin
            if (swap) begin
                written_mask <= '0;
            end else begin
                written_mask <= mask_next;
            end
            if (error_hit) begin
                write_error <= 1'b1;
            end
        end
    end

    assign bus.WRB_Write_Error = write_error;
`else
    assign bus.WRB_Write_Error = 1'b0;
`endif
endmodule
